vx_cache_evict_buf: RTL and testbench

Write-back eviction buffer sitting directly downstream of the cache bank data store in WRITEBACK mode. It accepts evicted lines (data plus dirty-byte mask) from the bank and queues them in FIFO order. It issues them as memory write requests over a valid/ready handshake. It also exposes an address-match port so the bank can hold a fill or refetch of a line whose write-back is still pending.

---
 rtl/vx_cache_evict_buf_pkg.sv | 20 ++
 rtl/vx_cache_evict_buf_cam.sv | 31 +++
 rtl/vx_cache_evict_buf.sv | 108 ++++++++++
 tb/tb_vx_cache_evict_buf.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/vx_cache_evict_buf_pkg.sv
// Shared types for the write-back eviction buffer: line geometry and the
// stored entry layout.
package vx_cache_evict_buf_pkg;

  localparam int LINE_SIZE       = 16;
  localparam int LINE_ADDR_WIDTH = 26;
  localparam int LINE_BITS       = LINE_SIZE * 8;

  typedef struct packed {
    logic [LINE_ADDR_WIDTH-1:0] addr;
    logic [LINE_BITS-1:0]       data;
    logic [LINE_SIZE-1:0]       byteen;
  } evict_entry_t;

  // A line carries write-back work only if at least one byte is dirty.
  function automatic logic is_dirty(input logic [LINE_SIZE-1:0] byteen);
    return |byteen;
  endfunction

endpackage

// File: rtl/vx_cache_evict_buf_cam.sv
// Address CAM over the circular buffer: a slot participates only when it
// lies inside the live window [rd_ptr, rd_ptr + count).
module vx_cache_evict_buf_cam
  import vx_cache_evict_buf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic [DEPTH-1:0][LINE_ADDR_WIDTH-1:0] i_entry_addr,
  input  logic [$clog2(DEPTH)-1:0]              i_rd_ptr,
  input  logic [$clog2(DEPTH):0]                i_count,
  input  logic [LINE_ADDR_WIDTH-1:0]            i_lookup_addr,
  output logic                                  o_hit
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0] w_valid;
  logic [DEPTH-1:0] w_match;

  for (genvar g = 0; g < DEPTH; g++) begin : g_way
    logic [PTR_W-1:0] w_offset;

    // Distance from the head, modulo DEPTH, tells whether the slot is live.
    assign w_offset   = PTR_W'(g) - i_rd_ptr;
    assign w_valid[g] = {1'b0, w_offset} < i_count;
    assign w_match[g] = w_valid[g] && (i_entry_addr[g] == i_lookup_addr);
  end

  assign o_hit = |w_match;

endmodule

// File: rtl/vx_cache_evict_buf.sv
// Write-back eviction buffer: FIFO of dirty evicted lines drained as memory
// write requests, with an address probe for pending write-backs.
module vx_cache_evict_buf
  import vx_cache_evict_buf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,

  input  logic                       i_evict_valid,
  output logic                       o_evict_ready,
  input  logic [LINE_ADDR_WIDTH-1:0] i_evict_addr,
  input  logic [LINE_BITS-1:0]       i_evict_data,
  input  logic [LINE_SIZE-1:0]       i_evict_byteen,

  output logic                       o_mem_req_valid,
  input  logic                       i_mem_req_ready,
  output logic [LINE_ADDR_WIDTH-1:0] o_mem_req_addr,
  output logic [LINE_BITS-1:0]       o_mem_req_data,
  output logic [LINE_SIZE-1:0]       o_mem_req_byteen,

  input  logic [LINE_ADDR_WIDTH-1:0] i_lookup_addr,
  output logic                       o_lookup_hit,

  output logic                       o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  evict_entry_t                         r_entries [DEPTH];
  logic         [PTR_W-1:0]             r_rd_ptr;
  logic         [PTR_W-1:0]             r_wr_ptr;
  logic         [CNT_W-1:0]             r_count;

  logic                                 w_push;
  logic                                 w_pop;
  logic                                 w_evict_dirty;
  logic                                 w_incoming_hit;
  logic                                 w_stored_hit;
  evict_entry_t                         w_in_entry;
  evict_entry_t                         w_head;
  logic [DEPTH-1:0][LINE_ADDR_WIDTH-1:0] w_entry_addr;

  assign w_evict_dirty = is_dirty(i_evict_byteen);

  // Ready comes from registered occupancy only; a same-cycle pop does not
  // open a slot for the offered eviction.
  assign o_evict_ready   = (r_count != CNT_W'(DEPTH));
  assign o_mem_req_valid = (r_count != '0);
  assign o_empty         = (r_count == '0);

  // Clean lines complete the handshake but are never stored.
  assign w_push = i_evict_valid && o_evict_ready && w_evict_dirty;
  assign w_pop  = o_mem_req_valid && i_mem_req_ready;

  assign w_in_entry = '{addr: i_evict_addr, data: i_evict_data, byteen: i_evict_byteen};

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
    end
  end

  // NOTE: payload storage is deliberately not reset; occupancy alone decides
  // which slots are meaningful, and skipping the reset keeps these plain flops.
  always_ff @(posedge clk) begin
    if (w_push) r_entries[r_wr_ptr] <= w_in_entry;
  end

  // Head slot is held until popped, so the request payload stays stable
  // while the memory side stalls.
  assign w_head           = r_entries[r_rd_ptr];
  assign o_mem_req_addr   = w_head.addr;
  assign o_mem_req_data   = w_head.data;
  assign o_mem_req_byteen = w_head.byteen;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_entry_addr[i] = r_entries[i].addr;
    end
  end

  vx_cache_evict_buf_cam #(
    .DEPTH (DEPTH)
  ) u_cam (
    .i_entry_addr  (w_entry_addr),
    .i_rd_ptr      (r_rd_ptr),
    .i_count       (r_count),
    .i_lookup_addr (i_lookup_addr),
    .o_hit         (w_stored_hit)
  );

  // An eviction on the wire this cycle must already block a refetch of it.
  assign w_incoming_hit = i_evict_valid && w_evict_dirty && (i_evict_addr == i_lookup_addr);
  assign o_lookup_hit   = w_stored_hit || w_incoming_hit;

endmodule

// File: tb/tb_vx_cache_evict_buf.sv
// Self-checking bench for vx_cache_evict_buf: directed scenarios followed by
// randomized traffic, checked against a queue-based reference model.
module tb_vx_cache_evict_buf;
  import vx_cache_evict_buf_pkg::*;

  localparam int DEPTH = 4;

  logic                       clk = 1'b0;
  logic                       reset;
  logic                       i_evict_valid;
  logic                       o_evict_ready;
  logic [LINE_ADDR_WIDTH-1:0] i_evict_addr;
  logic [LINE_BITS-1:0]       i_evict_data;
  logic [LINE_SIZE-1:0]       i_evict_byteen;
  logic                       o_mem_req_valid;
  logic                       i_mem_req_ready;
  logic [LINE_ADDR_WIDTH-1:0] o_mem_req_addr;
  logic [LINE_BITS-1:0]       o_mem_req_data;
  logic [LINE_SIZE-1:0]       o_mem_req_byteen;
  logic [LINE_ADDR_WIDTH-1:0] i_lookup_addr;
  logic                       o_lookup_hit;
  logic                       o_empty;

  vx_cache_evict_buf #(.DEPTH(DEPTH)) dut (
    .clk              (clk),
    .reset            (reset),
    .i_evict_valid    (i_evict_valid),
    .o_evict_ready    (o_evict_ready),
    .i_evict_addr     (i_evict_addr),
    .i_evict_data     (i_evict_data),
    .i_evict_byteen   (i_evict_byteen),
    .o_mem_req_valid  (o_mem_req_valid),
    .i_mem_req_ready  (i_mem_req_ready),
    .o_mem_req_addr   (o_mem_req_addr),
    .o_mem_req_data   (o_mem_req_data),
    .o_mem_req_byteen (o_mem_req_byteen),
    .i_lookup_addr    (i_lookup_addr),
    .o_lookup_hit     (o_lookup_hit),
    .o_empty          (o_empty)
  );

  always #5 clk = ~clk;

  // Reference model: lines accepted but not yet written back, oldest first.
  evict_entry_t exp_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;
  int  n_drained = 0;
  bit  sim_on   = 1'b0;
  bit  rand_phase = 1'b0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  function automatic logic [LINE_BITS-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Monitor: compares DUT outputs with the model at each falling edge and
  // retires the head entry when a write request is handshaken.
  always @(negedge clk) begin
    int sz;
    logic exp_hit;
    if (sim_on) begin
      sz = exp_q.size();
      check("evict_ready",   128'(o_evict_ready),   128'(sz != DEPTH));
      check("mem_req_valid", 128'(o_mem_req_valid), 128'(sz != 0));
      check("empty",         128'(o_empty),         128'(sz == 0));
      exp_hit = i_evict_valid && (i_evict_byteen != '0) && (i_evict_addr == i_lookup_addr);
      foreach (exp_q[i]) if (exp_q[i].addr == i_lookup_addr) exp_hit = 1'b1;
      check("lookup_hit", 128'(o_lookup_hit), 128'(exp_hit));
      if (sz != 0 && o_mem_req_valid) begin
        check("req_addr",   128'(o_mem_req_addr),   128'(exp_q[0].addr));
        check("req_data",   128'(o_mem_req_data),   128'(exp_q[0].data));
        check("req_byteen", 128'(o_mem_req_byteen), 128'(exp_q[0].byteen));
        if (i_mem_req_ready && !reset) begin
          void'(exp_q.pop_front());
          n_drained++;
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer one eviction and hold it until accepted (bounded wait).
  task automatic offer(input logic [LINE_ADDR_WIDTH-1:0] a,
                       input logic [LINE_BITS-1:0]       d,
                       input logic [LINE_SIZE-1:0]       be);
    bit acc;
    int waited;
    acc = 1'b0;
    waited = 0;
    i_evict_valid  = 1'b1;
    i_evict_addr   = a;
    i_evict_data   = d;
    i_evict_byteen = be;
    while (!acc) begin
      @(negedge clk);
      acc = o_evict_ready;
      @(posedge clk);
      if (acc && be != '0) exp_q.push_back('{addr: a, data: d, byteen: be});
      waited++;
      if (!acc && waited > 200) begin
        check("offer_timeout", 128'(0), 128'(1));
        break;
      end
    end
    #1;
    i_evict_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    exp_q.delete();
    #1;
    reset = 1'b0;
  endtask

  task automatic drain(input int budget);
    int c;
    c = 0;
    i_mem_req_ready = 1'b1;
    while (exp_q.size() != 0 && c < budget) begin
      @(posedge clk);
      c++;
    end
    #1;
    check("drain_done", 128'(exp_q.size()), 128'(0));
  endtask

  initial begin
    reset           = 1'b1;
    i_evict_valid   = 1'b0;
    i_evict_addr    = '0;
    i_evict_data    = '0;
    i_evict_byteen  = '0;
    i_mem_req_ready = 1'b0;
    i_lookup_addr   = '0;
    repeat (2) @(posedge clk);
    exp_q.delete();
    #1;
    reset  = 1'b0;
    sim_on = 1'b1;
    idle(3);

    // Single dirty line, memory always ready.
    i_mem_req_ready = 1'b1;
    offer(26'h100, rnd_data(), 16'hFFFF);
    idle(3);

    // Clean eviction: accepted, never forwarded.
    offer(26'h055, rnd_data(), 16'h0000);
    idle(3);

    // Fill to full with memory stalled, fifth offer waits for a free slot.
    i_mem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) offer(26'h10 + 26'(i), rnd_data(), 16'(16'h1 << i) | 16'h8000);
    idle(2);
    fork
      offer(26'h14, rnd_data(), 16'h00F0);
      begin
        repeat (3) @(posedge clk);
        #1;
        i_mem_req_ready = 1'b1;
      end
    join
    drain(50);
    check("full_drain_count", 128'(n_drained), 128'(6));

    // Lookup against stored and incoming lines.
    i_mem_req_ready = 1'b0;
    offer(26'h20, rnd_data(), 16'h0F0F);
    i_lookup_addr = 26'h20;
    idle(2);
    i_lookup_addr = 26'h21;
    idle(2);
    offer(26'h21, rnd_data(), 16'h0001);
    offer(26'h33, rnd_data(), 16'h0000);
    i_lookup_addr = 26'h33;
    idle(1);
    drain(50);

    // Steady push/pop at occupancy 2 across several pointer wraps.
    i_mem_req_ready = 1'b0;
    offer(26'h40, rnd_data(), 16'hFFFF);
    offer(26'h41, rnd_data(), 16'hFFFF);
    i_mem_req_ready = 1'b1;
    for (int i = 0; i < 8; i++) offer(26'h42 + 26'(i), rnd_data(), 16'(i + 1));
    check("steady_occupancy", 128'(exp_q.size()), 128'(2));
    do_reset();
    idle(3);

    // Randomized traffic from a small address pool so lookups hit often.
    rand_phase = 1'b1;
    fork
      while (rand_phase) begin
        @(posedge clk);
        #1;
        i_mem_req_ready = ($urandom_range(3) != 0);
        i_lookup_addr   = 26'h200 + 26'($urandom_range(7));
      end
    join_none
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(3) != 0)
        offer(26'h200 + 26'($urandom_range(7)), rnd_data(),
              ($urandom_range(4) == 0) ? 16'h0000 : 16'($urandom));
      else
        idle(1);
      if (i == 150) do_reset();
    end
    rand_phase = 1'b0;
    @(posedge clk);
    #1;
    drain(100);
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
